dtc_share_arb: RTL and testbench

Round-robin scheduler that shares one combinational decision-tree classifier (8-bit feature in, 2-bit class out) among N requesters. It registers the winning feature vector onto the classifier input and captures the class one cycle later. It then returns the class tagged with the requester ID over a valid/ready handshake. Per-class result counters are kept for monitoring. The block sits between feature producers and the classifier instance; the classifier itself is instantiated outside and wired to the `cls_*` ports.

---
 rtl/dtc_arb_pkg.sv | 21 ++
 rtl/dtc_rr_pick.sv | 32 +++
 rtl/dtc_share_arb.sv | 135 +++++++++++++
 tb/tb_dtc_share_arb.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtc_arb_pkg.sv
// Shared types and defaults for the classifier-sharing arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dtc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int FEAT_W_DEF = 8;
    localparam int CLS_W_DEF  = 2;
    localparam int CNT_W_DEF  = 16;

    // Bit offset of class counter 'cls' inside the packed histogram bus.
    function automatic int hist_lsb(input int cls, input int cnt_w);
        return cls * cnt_w;
    endfunction

endpackage

// File: rtl/dtc_rr_pick.sv
// Round-robin picker: first set request after 'last', wrapping around.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the pick is used.
module dtc_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan N_REQ positions starting just after 'last'; the first hit wins.
    always_comb begin
        int cand;
        cand = 0;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = (int'(last) + off) % N_REQ;
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = IDX_W'(cand);
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dtc_share_arb.sv
// Shares one combinational classifier among N_REQ requesters, round-robin.
// Latency: accept edge T, class captured at T+1, result valid until taken.
// Backpressure: while a result waits on res_ready, no new request is granted.
module dtc_share_arb
    import dtc_arb_pkg::*;
#(
    parameter  int N_REQ  = 4,
    parameter  int FEAT_W = FEAT_W_DEF,
    parameter  int CLS_W  = CLS_W_DEF,
    parameter  int CNT_W  = CNT_W_DEF,
    localparam int IDX_W  = $clog2(N_REQ),
    localparam int N_CLS  = 1 << CLS_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*FEAT_W-1:0] req_feat,
    output logic [N_REQ-1:0]        req_ready,
    output logic [FEAT_W-1:0]       cls_inp,
    input  logic [CLS_W-1:0]        cls_outp,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [CLS_W-1:0]        res_class,
    output logic [IDX_W-1:0]        res_id,
    input  logic                    hist_clr,
    output logic [N_CLS*CNT_W-1:0]  hist
);

    state_t             state_q, state_d;
    logic [FEAT_W-1:0]  cls_inp_q, cls_inp_d;
    logic [IDX_W-1:0]   id_q, id_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   res_id_q, res_id_d;
    logic [CLS_W-1:0]   res_class_q, res_class_d;
    logic [CNT_W-1:0]   hist_q [N_CLS];
    logic [CNT_W-1:0]   hist_d [N_CLS];

    logic [N_REQ-1:0]   pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [FEAT_W-1:0]  win_feat;
    logic               arb_en;
    logic               res_acc;

    dtc_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req  (req_valid),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign win_feat  = req_feat[int'(pick_idx)*FEAT_W +: FEAT_W];
    assign res_valid = (state_q == OUT);
    assign cls_inp   = cls_inp_q;
    assign res_class = res_class_q;
    assign res_id    = res_id_q;

    // Next state, arbitration window and classifier/result register loads.
    always_comb begin
        state_d     = state_q;
        cls_inp_d   = cls_inp_q;
        id_d        = id_q;
        last_d      = last_q;
        res_class_d = res_class_q;
        res_id_d    = res_id_q;
        arb_en      = 1'b0;
        res_acc     = 1'b0;
        case (state_q)
            IDLE: arb_en = 1'b1;
            EVAL: begin
                res_class_d = cls_outp;
                res_id_d    = id_q;
                state_d     = OUT;
            end
            OUT: begin
                if (res_ready) begin
                    res_acc = 1'b1;
                    arb_en  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (arb_en && pick_any) begin
            cls_inp_d = win_feat;
            id_d      = pick_idx;
            last_d    = pick_idx;
            state_d   = EVAL;
        end
        // Gated with rst_n so no grant is visible while reset is held.
        req_ready = (arb_en ? pick_gnt : '0) & {N_REQ{rst_n}};
    end

    // Saturating per-class counters; a clear overrides a same-cycle increment.
    always_comb begin
        for (int k = 0; k < N_CLS; k++) begin
            hist_d[k] = hist_q[k];
            if (hist_clr) begin
                hist_d[k] = '0;
            end else if (res_acc && (res_class_q == CLS_W'(k)) && (hist_q[k] != '1)) begin
                hist_d[k] = hist_q[k] + CNT_W'(1);
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cls_inp_q   <= '0;
            id_q        <= '0;
            last_q      <= IDX_W'(N_REQ - 1);
            res_class_q <= '0;
            res_id_q    <= '0;
            for (int k = 0; k < N_CLS; k++) hist_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            cls_inp_q   <= cls_inp_d;
            id_q        <= id_d;
            last_q      <= last_d;
            res_class_q <= res_class_d;
            res_id_q    <= res_id_d;
            for (int k = 0; k < N_CLS; k++) hist_q[k] <= hist_d[k];
        end
    end

    for (genvar k = 0; k < N_CLS; k++) begin : g_hist
        assign hist[hist_lsb(k, CNT_W) +: CNT_W] = hist_q[k];
    end

endmodule

// File: tb/tb_dtc_share_arb.sv
// Self-checking bench for dtc_share_arb (4 requesters, 4-bit counters).
// A transaction-level model predicts every output each cycle.
// Directed scenarios pin the model with hand-computed values.
module tb_dtc_share_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_feat;
    logic [3:0]  req_ready;
    logic [7:0]  cls_inp;
    logic [1:0]  cls_outp;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_class;
    logic [1:0]  res_id;
    logic        hist_clr;
    logic [15:0] hist;

    int n_pass = 0;
    int n_tot  = 0;

    dtc_share_arb #(
        .N_REQ  (4),
        .FEAT_W (8),
        .CLS_W  (2),
        .CNT_W  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_feat  (req_feat),
        .req_ready (req_ready),
        .cls_inp   (cls_inp),
        .cls_outp  (cls_outp),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_class (res_class),
        .res_id    (res_id),
        .hist_clr  (hist_clr),
        .hist      (hist)
    );

    assign cls_outp = cls_inp[1:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int       m_last;
    bit       m_fl_v;       // request granted, classification pending
    logic [7:0] m_fl_feat;
    int       m_fl_id;
    bit       m_pd_v;       // result waiting for the consumer
    int       m_pd_cls;
    int       m_pd_id;
    int       m_hist [4];

    task automatic model_reset();
        m_last = 3;
        m_fl_v = 0;
        m_pd_v = 0;
        m_fl_feat = '0;
        m_fl_id = 0;
        m_pd_cls = 0;
        m_pd_id = 0;
        for (int k = 0; k < 4; k++) m_hist[k] = 0;
    endtask

    // Compare at every falling edge, then advance the model across the next rising edge.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_reset();
                chk("rst_req_ready", req_ready, 0);
                chk("rst_res_valid", res_valid, 0);
                chk("rst_hist", hist, 0);
            end else begin
                bit         allowed;
                int         win;
                int         c;
                logic [3:0] exp_rr;
                allowed = !m_fl_v && (!m_pd_v || res_ready);
                win = -1;
                if (allowed) begin
                    for (int off = 1; off <= 4; off++) begin
                        c = (m_last + off) % 4;
                        if (win < 0 && req_valid[c]) win = c;
                    end
                end
                exp_rr = '0;
                if (win >= 0) exp_rr[win] = 1'b1;
                chk("req_ready", req_ready, exp_rr);
                chk("res_valid", res_valid, m_pd_v);
                if (m_pd_v) begin
                    chk("res_class", res_class, m_pd_cls);
                    chk("res_id", res_id, m_pd_id);
                end
                if (m_fl_v) chk("cls_inp", cls_inp, m_fl_feat);
                for (int k = 0; k < 4; k++) chk("hist", hist[k*4 +: 4], m_hist[k]);
                if (m_pd_v && res_ready) begin
                    if (m_hist[m_pd_cls] < 15) m_hist[m_pd_cls]++;
                    m_pd_v = 0;
                end
                if (m_fl_v) begin
                    m_pd_v = 1;
                    m_pd_cls = int'(m_fl_feat[1:0]);
                    m_pd_id = m_fl_id;
                    m_fl_v = 0;
                end
                if (win >= 0) begin
                    m_fl_v = 1;
                    m_fl_feat = req_feat[win*8 +: 8];
                    m_fl_id = win;
                    m_last = win;
                end
                if (hist_clr) for (int k = 0; k < 4; k++) m_hist[k] = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        res_ready = 1'b0;
        hist_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int ids [$];
        int gnts [$];
        int tms [$];
        int exp_seq [6];
        int cnt;
        int bad;
        int seen0;
        logic [3:0] acc;

        exp_seq = '{0, 1, 2, 3, 0, 1};
        rst_n = 1'b0;
        req_valid = '0;
        req_feat = '0;
        res_ready = 1'b0;
        hist_clr = 1'b0;

        // Reset values.
        do_reset();
        @(negedge clk);
        chk("reset_res_valid", res_valid, 0);
        chk("reset_res_class", res_class, 0);
        chk("reset_res_id", res_id, 0);
        chk("reset_cls_inp", cls_inp, 0);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_hist", hist, 0);

        // Single request: feature 0E -> class 2.
        step();
        req_valid = 4'b0001;
        req_feat[7:0] = 8'h0E;
        res_ready = 1'b1;
        @(negedge clk);
        chk("single_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;
        step();
        @(negedge clk);
        chk("single_res_valid", res_valid, 1);
        chk("single_res_class", res_class, 2);
        chk("single_res_id", res_id, 0);
        step();
        @(negedge clk);
        chk("single_hist2", hist[11:8], 1);

        // Round-robin fairness with all four requesters valid.
        do_reset();
        for (int i = 0; i < 4; i++) req_feat[i*8 +: 8] = 8'(8'h40 + i);
        req_valid = 4'hF;
        res_ready = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (req_ready[i]) gnts.push_back(i);
            if (res_valid && res_ready) begin
                ids.push_back(int'(res_id));
                tms.push_back(cyc);
            end
            step();
        end
        req_valid = '0;
        chk("rr_result_count_ge6", int'(ids.size() >= 6), 1);
        chk("rr_grant_count_ge6", int'(gnts.size() >= 6), 1);
        for (int i = 0; i < 6; i++) begin
            if (i < gnts.size()) chk("rr_grant_order", gnts[i], exp_seq[i]);
            if (i < ids.size()) chk("rr_res_id_order", ids[i], exp_seq[i]);
            if (i > 0 && i < tms.size()) chk("rr_spacing", tms[i] - tms[i-1], 2);
        end

        // Backpressure: requesters 1 and 2, consumer stalls for 5 cycles.
        do_reset();
        req_feat[15:8] = 8'h11;
        req_feat[23:16] = 8'h22;
        req_valid = 4'b0110;
        @(negedge clk);
        chk("bp_first_grant", req_ready, 4'b0010);
        step();
        req_valid = 4'b0100;
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", res_valid, 1);
            chk("bp_hold_class", res_class, 1);
            chk("bp_hold_id", res_id, 1);
            chk("bp_hold_ready", req_ready, 0);
            step();
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", req_ready, 4'b0100);
        step();
        req_valid = '0;
        repeat (4) step();

        // Saturation then clear on an accepting edge.
        do_reset();
        req_feat[7:0] = 8'h03;
        req_valid = 4'b0001;
        res_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 60 && cnt < 20; i++) begin
            @(negedge clk);
            if (res_valid && res_ready) cnt++;
            step();
        end
        chk("sat_results", cnt, 20);
        @(negedge clk);
        chk("sat_hist3", hist[15:12], 15);
        for (int i = 0; i < 6; i++) begin
            step();
            if (res_valid) break;
        end
        chk("clr_in_out", res_valid, 1);
        hist_clr = 1'b1;
        step();
        hist_clr = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("clr_hist3", hist[15:12], 0);
        repeat (3) step();

        // Async reset while evaluating.
        do_reset();
        req_feat[7:0] = 8'h07;
        req_valid = 4'b0001;
        res_ready = 1'b1;
        step();
        req_valid = '0;
        step();
        step();
        @(negedge clk);
        chk("ar_pre_hist3", hist[15:12], 1);
        chk("ar_pre_class", res_class, 3);
        step();
        req_feat[7:0] = 8'h0D;
        req_valid = 4'b0001;
        step();
        req_feat[31:24] = 8'h02;
        req_valid = 4'b1001;
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_res_valid", res_valid, 0);
        chk("ar_res_class", res_class, 0);
        chk("ar_res_id", res_id, 0);
        chk("ar_req_ready", req_ready, 0);
        chk("ar_hist", hist, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_first_grant", req_ready, 4'b0001);
        step();
        req_valid = 4'b1000;
        repeat (6) step();
        req_valid = '0;

        // Withdrawn request from requester 3 during evaluation.
        do_reset();
        req_feat[7:0] = 8'h05;
        req_valid = 4'b0001;
        res_ready = 1'b1;
        step();
        req_feat[31:24] = 8'h07;
        req_valid = 4'b1000;
        bad = 0;
        seen0 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (req_ready[3]) bad++;
            if (res_valid && res_id == 2'd3) bad++;
            if (res_valid && res_id == 2'd0) seen0++;
            step();
            req_valid = '0;
        end
        chk("wd_no_id3", bad, 0);
        chk("wd_one_result0", seen0, 1);

        // Randomised traffic against the model.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            step();
            for (int i = 0; i < 4; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) == 0);
                    req_feat[i*8 +: 8] = 8'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            hist_clr = ($urandom_range(0, 199) == 0);
        end
        req_valid = '0;
        hist_clr = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
